// File: rtl/mem_store_unit.sv
// mem_store_unit: store-side lane placement and memory write handshake.
// Places STB/STW data on the correct byte lane of the 16-bit memory word,
// builds the byte-enable mask and drives mem_write until mem_resp or timeout.
// Optional feature macro: STORE_ALIGN_CHECK_EN (word store to odd address aborts
// with error instead of writing).
module mem_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  input  logic        req_byte,
  output logic        done,
  output logic        error,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  output logic        mem_write,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic        timeout_hit;
  logic        misalign;
  logic [15:0] lane_data;
  logic [1:0]  lane_be;

  // Abort condition: last permitted WRITE cycle reached with no response
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (tmo_cnt == 8'(TIMEOUT - 1));
  end

  // Word store to an odd address (only flagged when the alignment check is built in)
  always_comb begin
`ifdef STORE_ALIGN_CHECK_EN
    misalign = !req_byte && req_addr[0];
`else
    misalign = 1'b0;
`endif
  end

  // Lane placement: bytes are replicated to both lanes, the mask selects one
  always_comb begin
    lane_data = req_data;
    lane_be   = 2'b11;
    if (req_byte) begin
      lane_data = {req_data[7:0], req_data[7:0]};
      lane_be   = req_addr[0] ? 2'b10 : 2'b01;
    end
  end

  // Control FSM with registered outputs and the WRITE timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      req_ready       <= 1'b1;
      done            <= 1'b0;
      error           <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      mem_write       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done  <= 1'b0;
          error <= 1'b0;
          if (req_valid && req_ready) begin
            mem_address     <= {req_addr[15:1], 1'b0};
            mem_wdata       <= lane_data;
            mem_byte_enable <= lane_be;
            req_ready       <= 1'b0;
            tmo_cnt         <= '0;
            if (misalign) begin
              done  <= 1'b1;
              error <= 1'b1;
              state <= S_DONE;
            end else begin
              mem_write <= 1'b1;
              state     <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A response on the final timeout edge takes priority over the abort
          if (mem_resp) begin
            mem_write <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b0;
            state     <= S_DONE;
          end else if (timeout_hit) begin
            mem_write <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          error     <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mem_write <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule
